// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder built from one full-adder cell
// (two half adders plus an OR) with a registered carry between bits.
// Operands are shifted LSB-first. The handshake is START/BUSY/DONE, and the
// result is held until the next operation completes.
// Optional build macro SERIAL_ADDER_SUB_EN adds the SUB input and the OVF output
// to give A-B subtraction with signed-overflow reporting.

// Half-adder cell: one sum bit and one carry bit.
module ha (
    input  logic A,
    input  logic B,
    output logic Su,
    output logic Ca
);
    assign Su = A ^ B;
    assign Ca = A & B;
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] SUM,
    output logic             COUT
`ifdef SERIAL_ADDER_SUB_EN
    ,
    input  logic             SUB,
    output logic             OVF
`endif
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    logic             load;
    logic             step;
    logic             last;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] s_sh;
    logic             carry;
    logic [CW-1:0]    cnt;

    // Full-adder cell: the first half adder combines the operand bits, and the
    // second adds the stored carry.
    logic prop;
    logic gen;
    logic carry_prop;
    logic sum_bit;
    logic carry_nx;

    ha u_ha0 (
        .A  (a_sh[0]),
        .B  (b_sh[0]),
        .Su (prop),
        .Ca (gen)
    );

    ha u_ha1 (
        .A  (prop),
        .B  (carry),
        .Su (sum_bit),
        .Ca (carry_prop)
    );

    assign carry_nx = gen | carry_prop;

    assign BUSY = (state == RUN);
    assign DONE = (state == FIN);

    // State register; reset aborts any operation in flight.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic plus the load/step strobes for the datapath.
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        step     = 1'b0;
        last     = 1'b0;
        case (state)
            IDLE: begin
                if (START) begin
                    load     = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt == LAST) begin
                    last     = 1'b1;
                    state_nx = FIN;
                end
            end
            FIN: begin
                // Accepting here gives back-to-back operations with no idle gap.
                if (START) begin
                    load     = 1'b1;
                    state_nx = RUN;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Operand shifters, the inter-bit carry, the partial sum and the bit counter.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            a_sh  <= '0;
            b_sh  <= '0;
            s_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (load) begin
            a_sh  <= A;
`ifdef SERIAL_ADDER_SUB_EN
            // Subtraction is A + ~B + 1, so CIN plays no part when SUB is set.
            b_sh  <= SUB ? ~B : B;
            carry <= SUB ? 1'b1 : CIN;
`else
            b_sh  <= B;
            carry <= CIN;
`endif
            s_sh  <= '0;
            cnt   <= '0;
        end else if (step) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            s_sh  <= {sum_bit, s_sh[WIDTH-1:1]};
            carry <= carry_nx;
            cnt   <= cnt + CW'(1);
        end
    end

    // Result registers change only on the final bit, so the previous result stays visible during RUN.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            SUM  <= '0;
            COUT <= 1'b0;
        end else if (last) begin
            SUM  <= {sum_bit, s_sh[WIDTH-1:1]};
            COUT <= carry_nx;
        end
    end

`ifdef SERIAL_ADDER_SUB_EN
    // Signed overflow: on the MSB step the stored carry is the carry into the MSB.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            OVF <= 1'b0;
        end else if (last) begin
            OVF <= carry ^ carry_nx;
        end
    end
`endif

endmodule
